// File: rtl/cond_dispatch.sv
// cond_dispatch: ARM issue stage that evaluates the condition field and hands each
// instruction to the branch or execute unit. Define COND_DISPATCH_STATS_EN for counters.
module cond_dispatch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic [3:0]       flags,
    output logic             br_en,
    output logic             br_cond,
    output logic             br_link,
    output logic [23:0]      br_offset,
    input  logic             br_busy,
    output logic             ex_en,
    output logic             ex_pass,
    output logic [31:0]      ex_instr,
    input  logic             ex_busy,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_skip
);

    typedef enum logic [2:0] {
        IDLE,
        BR_ISSUE,
        BR_ACK,
        BR_DONE,
        EX_ISSUE,
        EX_ACK,
        EX_DONE
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   is_branch;
    logic   cond_ok;

    // flags are {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'ha:    return n == v;
            4'hb:    return n != v;
            4'hc:    return !z && (n == v);
            4'hd:    return z || (n != v);
            4'he:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign instr_ready = (state == IDLE) && !br_busy && !ex_busy;
    assign accept      = instr_valid && instr_ready;
    assign is_branch   = (instr[27:25] == 3'b101);
    assign cond_ok     = cond_eval(instr[31:28], flags);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        br_en     = 1'b0;
        ex_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_branch ? BR_ISSUE : EX_ISSUE;
                end
            end
            BR_ISSUE: begin
                br_en     = 1'b1;
                state_nxt = BR_ACK;
            end
            BR_ACK: begin
                if (br_busy) begin
                    state_nxt = BR_DONE;
                end
            end
            BR_DONE: begin
                if (!br_busy) begin
                    state_nxt = IDLE;
                end
            end
            EX_ISSUE: begin
                ex_en     = 1'b1;
                state_nxt = EX_ACK;
            end
            EX_ACK: begin
                if (ex_busy) begin
                    state_nxt = EX_DONE;
                end
            end
            EX_DONE: begin
                if (!ex_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload is captured once on accept and held until the next accept, so the
    // target unit sees it stable for the whole transaction regardless of flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cond   <= 1'b0;
            br_link   <= 1'b0;
            br_offset <= '0;
            ex_pass   <= 1'b0;
            ex_instr  <= '0;
        end else if (accept) begin
            if (is_branch) begin
                br_cond   <= cond_ok;
                br_link   <= instr[24];
                br_offset <= instr[23:0];
            end else begin
                ex_pass   <= cond_ok;
                ex_instr  <= instr;
            end
        end
    end

`ifdef COND_DISPATCH_STATS_EN
    // Counted on the start pulse, when the latched cond/pass is already valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br   <= '0;
            stat_skip <= '0;
        end else begin
            if (br_en) begin
                stat_br <= stat_br + CNT_W'(1);
            end
            if ((br_en && !br_cond) || (ex_en && !ex_pass)) begin
                stat_skip <= stat_skip + CNT_W'(1);
            end
        end
    end
`else
    assign stat_br   = '0;
    assign stat_skip = '0;
`endif

endmodule

// File: tb/tb_cond_dispatch.sv
// Directed, table-driven bench for cond_dispatch; the bench drives the busy handshakes
// of both downstream units and checks pulses, payload, ready and counters.
module tb_cond_dispatch;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [3:0]       flags;
    logic             br_en;
    logic             br_cond;
    logic             br_link;
    logic [23:0]      br_offset;
    logic             br_busy;
    logic             ex_en;
    logic             ex_pass;
    logic [31:0]      ex_instr;
    logic             ex_busy;
    logic [CNT_W-1:0] stat_br;
    logic [CNT_W-1:0] stat_skip;

    cond_dispatch #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .flags       (flags),
        .br_en       (br_en),
        .br_cond     (br_cond),
        .br_link     (br_link),
        .br_offset   (br_offset),
        .br_busy     (br_busy),
        .ex_en       (ex_en),
        .ex_pass     (ex_pass),
        .ex_instr    (ex_instr),
        .ex_busy     (ex_busy),
        .stat_br     (stat_br),
        .stat_skip   (stat_skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  nzcv;
        logic        is_br;
        logic        cond;
        int          ack_dly;
        int          busy_len;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_br   = '0;
    logic [CNT_W-1:0] exp_skip = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef COND_DISPATCH_STATS_EN
        check({tag, ".stat_br"}, 32'(stat_br), 32'(exp_br));
        check({tag, ".stat_skip"}, 32'(stat_skip), 32'(exp_skip));
`else
        check({tag, ".stat_br"}, 32'(stat_br), 32'h0);
        check({tag, ".stat_skip"}, 32'(stat_skip), 32'h0);
`endif
    endtask

    // One full transaction: accept, start pulse, delayed busy, busy fall, back to ready.
    task automatic run_vec(input vec_t v, input string tag, input bit full);
        logic [31:0] w;
        w = v.word;
        @(negedge clk);
        instr       = w;
        flags       = v.nzcv;
        instr_valid = 1'b1;
        #1;
        if (full) check({tag, ".ready_acc"}, 32'(instr_ready), 32'h1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        flags       = ~v.nzcv;
        check({tag, ".br_en"}, 32'(br_en), 32'(v.is_br));
        check({tag, ".ex_en"}, 32'(ex_en), 32'(!v.is_br));
        if (v.is_br) begin
            check({tag, ".br_cond"}, 32'(br_cond), 32'(v.cond));
            if (full) begin
                check({tag, ".br_link"}, 32'(br_link), 32'(w[24]));
                check({tag, ".br_offset"}, 32'(br_offset), 32'(w[23:0]));
            end
            exp_br++;
        end else begin
            check({tag, ".ex_pass"}, 32'(ex_pass), 32'(v.cond));
            check({tag, ".ex_instr"}, ex_instr, w);
        end
        if (!v.cond) exp_skip++;
        if (full) check({tag, ".ready_busy"}, 32'(instr_ready), 32'h0);
        for (int i = 0; i <= v.ack_dly; i++) begin
            @(posedge clk);
            #1;
            if (full || i == 0) begin
                check({tag, ".no_pulse_ack"}, 32'({br_en, ex_en}), 32'h0);
                check({tag, ".ready_ack"}, 32'(instr_ready), 32'h0);
            end
        end
        if (v.is_br) br_busy = 1'b1; else ex_busy = 1'b1;
        for (int i = 0; i < v.busy_len; i++) begin
            @(posedge clk);
            #1;
            if (full) check({tag, ".no_pulse_busy"}, 32'({br_en, ex_en}), 32'h0);
        end
        br_busy = 1'b0;
        ex_busy = 1'b0;
        #1;
        if (full) check({tag, ".ready_done"}, 32'(instr_ready), 32'h0);
        @(posedge clk);
        #1;
        check({tag, ".ready_idle"}, 32'(instr_ready), 32'h1);
        if (full) begin
            if (v.is_br) check({tag, ".br_cond_held"}, 32'(br_cond), 32'(v.cond));
            else         check({tag, ".ex_pass_held"}, 32'(ex_pass), 32'(v.cond));
            check_stats(tag);
        end
    endtask

    vec_t vecs[16];
    vec_t fast_br;

    initial begin
        //        word          NZCV     br    cond  ack busy
        vecs[0]  = '{32'hEA000002, 4'b0000, 1'b1, 1'b1, 0, 1};  // BAL +2
        vecs[1]  = '{32'h1BFFFFFE, 4'b0100, 1'b1, 1'b0, 0, 2};  // BLNE, Z=1
        vecs[2]  = '{32'hC0812003, 4'b1001, 1'b0, 1'b1, 0, 1};  // ADDGT, N=V=1
        vecs[3]  = '{32'hEA000010, 4'b0000, 1'b1, 1'b1, 3, 2};  // BAL, slow busy
        vecs[4]  = '{32'hFA000005, 4'b1111, 1'b1, 1'b0, 0, 1};  // NV
        vecs[5]  = '{32'h0A000100, 4'b0100, 1'b1, 1'b1, 1, 1};  // BEQ, Z=1
        vecs[6]  = '{32'h80000000, 4'b0110, 1'b0, 1'b0, 0, 3};  // HI, C=1 Z=1
        vecs[7]  = '{32'hB3A00001, 4'b1000, 1'b0, 1'b1, 2, 1};  // MOVLT, N!=V
        vecs[8]  = '{32'hDA000000, 4'b0001, 1'b1, 1'b1, 0, 1};  // BLE, N!=V
        vecs[9]  = '{32'h25900000, 4'b0000, 1'b0, 1'b0, 0, 1};  // LDRCS, C=0
        vecs[10] = '{32'hAB00ABCD, 4'b1001, 1'b1, 1'b1, 0, 1};  // BLGE, N=V
        vecs[11] = '{32'hE8BD0001, 4'b0000, 1'b0, 1'b1, 0, 1};  // LDM (class 100)
        vecs[12] = '{32'h4A000001, 4'b0000, 1'b1, 1'b0, 0, 1};  // BMI, N=0
        vecs[13] = '{32'h9A800000, 4'b0010, 1'b1, 1'b0, 0, 1};  // BLS, C=1 Z=0
        vecs[14] = '{32'h7A000000, 4'b0001, 1'b1, 1'b0, 0, 1};  // BVC, V=1
        vecs[15] = '{32'h50000000, 4'b0000, 1'b0, 1'b1, 0, 1};  // PL, N=0
        fast_br  = '{32'hEA000001, 4'b0000, 1'b1, 1'b1, 0, 1};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        flags       = 4'h0;
        br_busy     = 1'b0;
        ex_busy     = 1'b0;
        #12;
        check("reset.br_en", 32'(br_en), 32'h0);
        check("reset.ex_en", 32'(ex_en), 32'h0);
        check("reset.br_offset", 32'(br_offset), 32'h0);
        check("reset.ex_instr", ex_instr, 32'h0);
        check_stats("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.ready", 32'(instr_ready), 32'h1);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Stale busy while idle: nothing accepted, no pulse.
        @(negedge clk);
        ex_busy     = 1'b1;
        instr       = 32'hE0812003;
        instr_valid = 1'b1;
        #1;
        check("stale.ready", 32'(instr_ready), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stale.no_pulse", 32'({br_en, ex_en}), 32'h0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        ex_busy     = 1'b0;
        #1;
        check("stale.ready_after", 32'(instr_ready), 32'h1);
        @(posedge clk);
        #1;
        check("stale.no_late_pulse", 32'({br_en, ex_en}), 32'h0);

        // Reset while in BR_DONE abandons the branch.
        @(negedge clk);
        instr       = 32'hEB123456;
        flags       = 4'h0;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("rst.br_en", 32'(br_en), 32'h1);
        @(posedge clk);
        #1;
        br_busy = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_br   = '0;
        exp_skip = '0;
        check("rst.br_en_clr", 32'(br_en), 32'h0);
        check("rst.br_cond_clr", 32'(br_cond), 32'h0);
        check("rst.br_link_clr", 32'(br_link), 32'h0);
        check("rst.br_offset_clr", 32'(br_offset), 32'h0);
        check("rst.ex_pass_clr", 32'(ex_pass), 32'h0);
        check("rst.ex_instr_clr", ex_instr, 32'h0);
        check_stats("rst");
        check("rst.ready_busy", 32'(instr_ready), 32'h0);
        br_busy = 1'b0;
        #1;
        check("rst.ready_free", 32'(instr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst.no_resend", 32'({br_en, ex_en}), 32'h0);
        end
        check("rst.ready_after", 32'(instr_ready), 32'h1);

        // 2^CNT_W branches wrap the branch counter back to zero.
        for (int i = 0; i < (1 << CNT_W); i++) begin
            run_vec(fast_br, "wrap", 1'b0);
            if (i == (1 << CNT_W) - 2) check_stats("wrap.pre");
        end
        check_stats("wrap.post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
